// File: rtl/slug_uart_pkg.sv
// Shared types, constants and helpers for the slug UART report path.
package slug_uart_pkg;

   localparam logic [7:0]  CHAR_CR     = 8'h0D;
   localparam logic [7:0]  CHAR_LF     = 8'h0A;
   localparam int unsigned FRAME_CHARS = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_DONE
   } frame_state_t;

   // Uppercase ASCII hex digit for one nibble.
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10) return 8'h30 + {4'h0, nib};
      else             return 8'h37 + {4'h0, nib};
   endfunction

   // clk cycles per UART bit.
   function automatic int baud_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, DIV clk per bit.
module uart_tx_byte
   import slug_uart_pkg::*;
#(
   parameter int unsigned DIV = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       done,
   output logic       tx
);

   localparam int unsigned BW = (DIV > 2) ? $clog2(DIV) : 1;

   logic          active;
   logic [3:0]    bit_cnt;
   logic [BW-1:0] baud_cnt;
   logic [8:0]    shreg;
   logic          last_tick;

   assign last_tick = active && (baud_cnt == BW'(DIV - 1));
   assign done      = last_tick && (bit_cnt == 4'd9);
   // Ready in the done cycle so the caller sees both at once.
   assign ready     = !active || done;

   // Bit/baud counters and the registered tx pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active   <= 1'b0;
         bit_cnt  <= '0;
         baud_cnt <= '0;
         shreg    <= '1;
         tx       <= 1'b1;
      end else if (valid && ready) begin
         active   <= 1'b1;
         bit_cnt  <= '0;
         baud_cnt <= '0;
         shreg    <= {1'b1, data};
         tx       <= 1'b0;
      end else if (done) begin
         active   <= 1'b0;
         tx       <= 1'b1;
      end else if (active) begin
         if (last_tick) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
            tx       <= shreg[0];
            shreg    <= {1'b1, shreg[8:1]};
         end else begin
            baud_cnt <= baud_cnt + BW'(1);
         end
      end
   end

endmodule

// File: rtl/port_uart_tx.sv
// Reports every change of port_value as "XXXXXXXX\r\n" over UART 8N1.
module port_uart_tx
   import slug_uart_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 115200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] port_value,
   output logic        tx,
   output logic        busy,
   output logic [15:0] frame_count
);

   localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);

   frame_state_t state, state_nxt;
   logic [31:0]  snapshot;
   logic [31:0]  last_sent;
   logic         force_send;
   logic [3:0]   char_idx;
   logic         trigger;
   logic [7:0]   byte_data;
   logic         byte_valid;
   logic         byte_ready;
   logic         byte_done;
   logic [31:0]  snap_shifted;
   logic         last_char;

   assign trigger      = force_send || (port_value != last_sent);
   assign busy         = (state != ST_IDLE);
   assign snap_shifted = snapshot >> {3'd7 - char_idx[2:0], 2'b00};
   assign last_char    = (char_idx == 4'(FRAME_CHARS - 1));

   // Character mux. The first character is launched from IDLE straight off
   // port_value so the start bit lands one cycle after capture.
   always_comb begin
      byte_data = hex_ascii(port_value[31:28]);
      if (state == ST_SEND) begin
         case (char_idx)
            4'd8:    byte_data = CHAR_CR;
            4'd9:    byte_data = CHAR_LF;
            default: byte_data = hex_ascii(snap_shifted[3:0]);
         endcase
      end
   end

   // Next-state and serializer handshake.
   always_comb begin
      state_nxt  = state;
      byte_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            byte_valid = trigger;
            if (trigger) state_nxt = ST_SEND;
         end
         ST_SEND: begin
            byte_valid = byte_ready && !byte_done;
            if (byte_done && last_char) state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Frame FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Change detector, snapshot, character index and frame counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snapshot    <= '0;
         last_sent   <= '0;
         force_send  <= 1'b1;
         char_idx    <= '0;
         frame_count <= '0;
      end else begin
         case (state)
            ST_IDLE: if (trigger) begin
               snapshot   <= port_value;
               last_sent  <= port_value;
               force_send <= 1'b0;
               char_idx   <= '0;
            end
            ST_SEND: if (byte_done && !last_char) char_idx <= char_idx + 4'd1;
            ST_DONE: frame_count <= frame_count + 16'd1;
            default: ;
         endcase
      end
   end

   uart_tx_byte #(.DIV(DIV)) u_byte (
      .clk   (clk),
      .rst   (rst),
      .data  (byte_data),
      .valid (byte_valid),
      .ready (byte_ready),
      .done  (byte_done),
      .tx    (tx)
   );

endmodule

// File: doc/port_uart_tx.md
Name: port_uart_tx

Overview:
- Downstream consumer of the slug core's 32-bit port_out, on the Arty board beside the LED tap.
- On every change of the port value, and once after reset, transmits the value as 8 uppercase ASCII hex digits followed by CR LF.
- Transmission is UART 8N1 on one TX pin, so program output is visible on the board's USB-UART without a debugger.
- Runs in the PLL clk domain.

Parameters:
- CLK_HZ, 100_000_000, frequency of clk in Hz.
- BAUD, 115200, line rate in bits per second.
- DIV, CLK_HZ/BAUD (integer division), clk cycles per bit; 868 at defaults; must be >= 2.

Ports:
- clk  input  1  system clock (PLL output).
- rst  input  1  asynchronous, active-high reset.
- port_value  input  32  value to report; driven by slug port_out, synchronous to clk.
- tx  output  1  UART serial out; idles high.
- busy  output  1  high while a frame (10 characters) is in flight.
- frame_count  output  16  number of completed frames; wraps 0xFFFF -> 0x0000.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: tx=1, busy=0, frame_count=0, last_sent=0, force_send=1, FSM=IDLE. tx goes high immediately on rst assertion, including mid-bit.
- FSM states:
  - IDLE: each cycle, if force_send or port_value != last_sent, then snapshot <= port_value, last_sent <= port_value, force_send <= 0, char_idx <= 0, go to SEND. Otherwise stay.
  - SEND: present char[char_idx] to the byte serializer. On its done pulse: if char_idx == 9, go to DONE; else char_idx++ and the next character starts on the following cycle.
  - DONE: frame_count++ (modulo 2^16), go to IDLE.
- busy = (state != IDLE).
- Timing: capture in cycle N; start bit (tx=0) begins at N+1.
- Frame content:
  - Characters 0..7 are snapshot nibbles, MSB nibble first. Nibble 0-9 -> 0x30-0x39; nibble A-F -> 0x41-0x46.
  - Character 8 = 0x0D; character 9 = 0x0A.
- Byte framing: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly DIV cycles.
- Consecutive characters within a frame are back-to-back, with no idle gap after the stop bit beyond 1 cycle.
- tx is high for >= 2 cycles between frames (DONE + IDLE).
- The frame is built only from snapshot. port_value changes during a frame do not alter it.
- After a frame, the IDLE compare uses the current port_value. Intermediate values seen only mid-frame are dropped; the latest value is sent.
- A stable port_value produces no traffic after the first frame.
- Reset mid-frame: frame aborted, frame_count not incremented. After release, force_send=1, so the current value is sent.
- tx is driven from a flop (glitch-free pin).

Decomposition:
- Package slug_uart_pkg:
  - function hex_ascii(logic[3:0]) -> logic[7:0].
  - constants CHAR_CR=8'h0D, CHAR_LF=8'h0A, FRAME_CHARS=10.
  - function baud_div(int clk_hz, int baud).
  - enum typedef for the frame FSM state.
- Sub-module uart_tx_byte(clk, rst, data[7:0], valid, ready, done, tx), parameter DIV:
  - Accepts a byte when valid && ready.
  - Owns the bit counter (0..9) and the baud counter (0..DIV-1).
  - Pulses done for 1 cycle at the end of the stop bit.
  - ready is high in the same cycle as done.
- port_uart_tx holds the change detector, snapshot, frame FSM, character mux and frame_count.

Test Plan (bench uses CLK_HZ=1000, BAUD=100 -> DIV=10; UART monitor samples at mid-bit):
- Reset with port_value=0, release -> tx=1 and busy=0 during reset. After release, a frame decodes to "00000000\r\n" (bytes 0x30 x8, 0x0D, 0x0A). Each bit is 10 cycles; frame = 1000 cycles ± idle cycles; frame_count=1.
- port_value=32'hDEADBEEF after the first frame -> "DEADBEEF\r\n". The first start bit falls 1 cycle after the capture cycle; frame_count=2.
- Hold port_value constant for 5000 cycles -> tx stays 1, busy=0, frame_count unchanged.
- During a frame for 0x00000001, drive 0x00000002 then 0x00000003 -> the first frame is unaltered. Exactly one following frame, "00000003\r\n"; no frame for 0x2.
- Assert rst at bit 4 of character 3, hold 3 cycles, set port_value=32'h0000000A -> tx=1 within the reset cycle, busy=0, frame_count=0. After release, "0000000A\r\n" is sent.
- Preload frame_count=0xFFFF via 65535 forced changes (or hierarchical force), complete one more frame -> frame_count=0x0000.
